// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock with a borrow register between bits.
// Start accepted in IDLE or DONE; o_done pulses N+1 cycles after the accepting edge.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_diff,
  output logic         o_borrow,
  output logic         o_overflow
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res;
  logic [CW-1:0] cnt;
  logic          br;
  logic          a_msb;
  logic          b_msb;

  logic a0;
  logic b0;
  logic d;
  logic br_next;
  logic last_bit;

  assign a0       = a_sr[0];
  assign b0       = b_sr[0];
  assign d        = a0 ^ b0 ^ br;
  assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
  assign last_bit = (cnt == CW'(N - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_diff     <= '0;
      o_borrow   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_sr   <= i_a;
            b_sr   <= i_b;
            a_msb  <= i_a[N-1];
            b_msb  <= i_b[N-1];
            res    <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            o_busy <= 1'b1;
            state  <= RUN;
          end else begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= {d, res[N-1:1]};
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          // Results publish only on the final bit so no partial value is ever visible.
          if (last_bit) begin
            o_diff     <= {d, res[N-1:1]};
            o_borrow   <= br_next;
            o_overflow <= (a_msb ^ b_msb) & (d ^ a_msb);
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (N=8) with hand-computed results.
module tb_serial_subtractor;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_diff;
  logic       o_borrow;
  logic       o_overflow;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] prev_diff = 8'h00;

  serial_subtractor #(.N(8)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_diff    (o_diff),
    .o_borrow  (o_borrow),
    .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, o_busy, 0);
    check_val({tag, "_done"}, o_done, 0);
    check_val({tag, "_diff"}, o_diff, 0);
    check_val({tag, "_borrow"}, o_borrow, 0);
    check_val({tag, "_ovf"}, o_overflow, 0);
  endtask

  // One start pulse; optionally hammer i_start/i_a/i_b during RUN to show they are ignored.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb, input logic eo, input bit noise);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge i_clk);
    i_start = 1'b1;
    i_a = a;
    i_b = b;
    cyc = 0;
    busy_cnt = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge i_clk);
      cyc++;
      if (o_done) begin
        seen = 1;
      end else begin
        if (o_busy) busy_cnt++;
        check_val({tag, "_hold"}, o_diff, prev_diff);
      end
      if (noise && cyc < 6) begin
        i_start = 1'b1;
        i_a = 8'hFF;
        i_b = 8'hFF;
      end else begin
        i_start = 1'b0;
      end
    end
    check_val({tag, "_done_seen"}, seen, 1);
    check_val({tag, "_latency"}, cyc, 9);
    check_val({tag, "_busy_cycles"}, busy_cnt, 8);
    check_val({tag, "_busy_at_done"}, o_busy, 0);
    check_val({tag, "_diff"}, o_diff, ed);
    check_val({tag, "_borrow"}, o_borrow, eb);
    check_val({tag, "_ovf"}, o_overflow, eo);
    prev_diff = ed;
    @(negedge i_clk);
    check_val({tag, "_done_pulse"}, o_done, 0);
  endtask

  initial begin
    int cyc;
    int last;
    int nd;

    i_reset = 1'b1;
    i_start = 1'b0;
    i_a = 8'h00;
    i_b = 8'h00;
    #12;
    check_all_zero("reset");
    @(negedge i_clk);
    i_reset = 1'b0;

    run_op("5m3",   8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    run_op("3m5",   8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    run_op("0m0",   8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    run_op("80m01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    run_op("7Fm FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0);
    run_op("ignore", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1);

    // Back-to-back: start held high gives a result every N+1 cycles.
    @(negedge i_clk);
    i_start = 1'b1;
    i_a = 8'h09;
    i_b = 8'h04;
    cyc = 0;
    last = -1;
    nd = 0;
    while (nd < 3 && cyc < 60) begin
      @(negedge i_clk);
      cyc++;
      if (o_done) begin
        check_val("b2b_diff", o_diff, 8'h05);
        if (last >= 0) check_val("b2b_spacing", cyc - last, 9);
        last = cyc;
        nd++;
        if (nd == 3) begin
          i_start = 1'b0;
        end else begin
          @(negedge i_clk);
          cyc++;
          check_val("b2b_busy_after_done", o_busy, 1);
          check_val("b2b_done_drop", o_done, 0);
        end
      end
    end
    check_val("b2b_count", nd, 3);
    prev_diff = 8'h05;
    @(negedge i_clk);

    // Asynchronous reset between edges in the 4th RUN cycle.
    @(negedge i_clk);
    i_start = 1'b1;
    i_a = 8'hAA;
    i_b = 8'h11;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge i_clk);
    i_reset = 1'b0;
    prev_diff = 8'h00;

    run_op("20m01", 8'h20, 8'h01, 8'h1F, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit unsigned/two's-complement subtractor computing A − B, LSB first, one bit per clock.
- Reuses the full-adder bit equations in the inverse sense: difference plus a borrow register carried between bits.
- Start/done handshake. Sits beside the combinational adders as the area-minimal sequential arithmetic unit.

Parameters:
- N, 8, operand and result width in bits (N ≥ 2).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_start  input  1  request; sampled on rising edge when not busy.
- i_a  input  N  minuend; captured on accepted start.
- i_b  input  N  subtrahend; captured on accepted start.
- o_busy  output  1  high while a subtraction is in progress.
- o_done  output  1  one-cycle pulse when results are valid.
- o_diff  output  N  A − B mod 2^N; held until next accepted start.
- o_borrow  output  1  final borrow; 1 iff A < B unsigned.
- o_overflow  output  1  signed overflow of A − B.

Behaviour:
- Reset: asynchronous, active-high; effective immediately on assertion, including mid-operation, and overrides all other inputs.
  - State → IDLE.
  - o_busy, o_done, o_borrow, o_overflow = 0; o_diff = 0.
  - Internal shift registers, bit counter and borrow register = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - i_start = 1 at an edge → latch i_a/i_b into shift registers, clear borrow and counter, go to RUN.
  - Otherwise stay in IDLE. Outputs hold their last values.
- RUN (o_busy = 1): each edge processes one bit.
  - a0, b0 = current LSBs of the shift registers; br = borrow register.
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d is shifted into the MSB of the result register; operand registers shift right; counter increments.
  - On the edge that processes bit N−1: go to DONE. o_diff = full result, o_borrow = br_next, o_overflow = (a_msb ≠ b_msb) & (d_msb ≠ a_msb), using the latched operand MSBs.
- DONE (o_done = 1, o_busy = 0), lasts exactly one cycle.
  - i_start = 1 is accepted here exactly as in IDLE, allowing back-to-back operations → RUN.
  - Otherwise → IDLE.
- Latency: start accepted at edge k → o_done high in the cycle after edge k+N. o_busy is high for exactly N cycles. Throughput: one result per N+1 cycles.
- During RUN:
  - i_start is ignored.
  - i_a/i_b changes have no effect on the result.
  - o_diff, o_borrow and o_overflow keep their previous result values; no partial values are visible.
- Width: all arithmetic is modulo 2^N, with no sign extension.
  - o_borrow is the unsigned comparison flag.
  - o_overflow is meaningful only under a signed interpretation.
- No X propagation from undriven i_a/i_b while idle: operands are captured only on an accepted start.

Test Plan:
- N=8, i_a=0x05, i_b=0x03, 1-cycle start pulse → o_busy high 8 cycles; o_done pulses in the 9th cycle after the start edge; o_diff=0x02, o_borrow=0, o_overflow=0.
- i_a=0x03, i_b=0x05 → o_diff=0xFE, o_borrow=1, o_overflow=0. Separately, i_a=0x00, i_b=0x00 → o_diff=0x00, all flags 0.
- i_a=0x80, i_b=0x01 → o_diff=0x7F, o_borrow=0, o_overflow=1. Separately, i_a=0x7F, i_b=0xFF → o_diff=0x80, o_borrow=1, o_overflow=1.
- Start 0x10−0x01, then during RUN drive i_start=1 and i_a=0xFF, i_b=0xFF → ignored; result 0x0F. o_diff holds its previous value until o_done.
- Hold i_start=1 continuously with 0x09−0x04 → o_done every 9 cycles with o_diff=0x05 each time; o_busy rises in the cycle after each o_done.
- Assert i_reset between edges on the 4th RUN cycle → all outputs 0 immediately, before the next edge. Release, then start 0x20−0x01 → o_diff=0x1F after normal latency.
